ospi_cmd_sequencer: RTL and testbench
=====================================

Name: ospi_cmd_sequencer

Overview:
Host-side command sequencer that sits directly upstream of the OSPI flash model. It accepts byte-level read, write and erase requests over a valid/ready interface. It converts each request into a timed flash access: chip-select setup, a single-cycle strobe, read-latency wait and chip-select hold. It returns a response (read data and error flag) over a second valid/ready interface.

Parameters:
ADDR_W, 24, flash address width
CS_SETUP, 1, cycles f_cs_n is low before the strobe cycle (min 1)
CS_HOLD, 1, cycles f_cs_n stays low after the strobe or read sample (min 1)
RD_LAT, 1, cycles after the read strobe before f_data_out is sampled (min 1)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_op  in  2  00 read, 01 write, 10 erase, 11 reserved
req_addr  in  ADDR_W  byte address
req_wdata  in  8  write data
req_mode  in  2  lane mode forwarded to the flash
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_rdata  out  8  read data; 0xFF for write, erase or error
rsp_err  out  1  request failed
hold_req  in  1  system hold request
busy  out  1  FSM not in IDLE
f_cs_n  out  1  flash chip select, active-low
f_write_enable  out  1  write strobe
f_read_enable  out  1  read strobe
f_erase_enable  out  1  erase strobe
f_address  out  ADDR_W  flash address
f_data_in  out  8  flash write data
f_mode  out  2  flash lane mode
f_hold_n  out  1  flash hold, active-low
f_data_out  in  8  flash registered read data

Behaviour:
- All outputs are registered.
- Reset values: req_ready 0 during reset, 1 from the first cycle after release. rsp_valid 0, rsp_rdata 0xFF, rsp_err 0, busy 0, f_cs_n 1, all strobes 0, f_address 0, f_data_in 0, f_mode 0, f_hold_n 1.
- Reset asserted mid-operation aborts the access immediately; no response is produced for the aborted request.
- f_hold_n = ~hold_req, registered with one cycle of delay, in every state.
- FSM states: IDLE, SETUP, EXEC, WAIT, CSHOLD, RESP.
- IDLE:
  - req_valid && req_ready captures op, addr, wdata and mode.
  - Op 11 goes straight to RESP with rsp_err=1, rsp_rdata=0xFF and no flash activity.
  - Any other op goes to SETUP and drives f_cs_n low, f_address, f_data_in and f_mode.
- SETUP:
  - Counts CS_SETUP cycles, then goes to EXEC.
  - If hold_req is high, the counter freezes and EXEC is not entered. f_cs_n stays low.
- EXEC:
  - Exactly one cycle with the matching strobe high; it is never stretched.
  - hold_req arriving in EXEC does not abort the access.
  - Read goes to WAIT; write and erase go to CSHOLD.
- WAIT:
  - Counts RD_LAT cycles.
  - f_data_out is sampled into rsp_rdata on the last WAIT cycle, then goes to CSHOLD.
- CSHOLD: strobes low, f_cs_n low for CS_HOLD cycles, then f_cs_n goes high and the FSM enters RESP.
- RESP:
  - rsp_valid=1 and is held stable until rsp_ready; then returns to IDLE.
  - rsp_ready already high on entry completes the response in one cycle.
- Back-to-back requests: f_cs_n is high for at least one cycle (the RESP cycle) between accesses.
- Read latency with defaults, handshake at T0: SETUP T1, strobe T2, sample T3, CSHOLD T4, rsp_valid T5.
- Counters are clog2(max(param)+1) wide, load param-1 and decrement to 0. They do not wrap.
- At most one strobe is high in any cycle.

Optional Feature:
OSPI_SEQ_VERIFY_EN
- Defined: after a write's CSHOLD, the FSM deasserts f_cs_n for one cycle, then runs a full read sequence (SETUP/EXEC/WAIT/CSHOLD) at the same address and compares the result with the written data.
  - Mismatch: rsp_err=1.
  - rsp_rdata carries the read-back value.
  - Write latency grows by CS_SETUP+RD_LAT+CS_HOLD+2 cycles.
- Undefined: writes respond with rsp_rdata=0xFF and rsp_err=0; no read-back logic is present.

Decomposition:
- Package ospi_pkg holds:
  - op encodings (OP_READ, OP_WRITE, OP_ERASE, OP_RSVD);
  - mode encodings (MODE_X1, MODE_NIB, MODE_X2PAIR, MODE_X8);
  - the state enum;
  - the ERASED_BYTE=0xFF constant.
- Sub-module ospi_cycle_timer: loadable down-counter with freeze input and done flag, shared by SETUP, WAIT and CSHOLD.

Test Plan:
- Write 0x5A at 0x000010, then read 0x000010 → one f_write_enable pulse with f_cs_n low; response rsp_rdata=0x5A, rsp_err=0; read rsp_valid arrives 5 cycles after the handshake (defaults).
- Erase 0x000010, then read → rsp_rdata=0xFF, rsp_err=0.
- req_op=11 → rsp_valid on the next cycle, rsp_err=1, rsp_rdata=0xFF; f_cs_n never low.
- hold_req high during SETUP for 4 cycles → no strobe while held; f_hold_n low one cycle after hold_req; access completes once hold_req drops, with correct data.
- rsp_ready low for 3 cycles in RESP → rsp_valid and data stable, req_ready=0; reset asserted mid-EXEC → f_cs_n=1 and strobes 0 immediately, no response after reset release.
- With OSPI_SEQ_VERIFY_EN defined and f_data_out forced to 0x00 during read-back of a 0x5A write → rsp_err=1, rsp_rdata=0x00.

Source files
------------

// File: rtl/ospi_cmd_sequencer_pkg.sv
// Shared encodings for the OSPI command sequencer: op codes, lane modes,
// FSM state codes and the erased-flash byte value.
package ospi_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] MODE_X1     = 2'b00;
  localparam logic [1:0] MODE_NIB    = 2'b01;
  localparam logic [1:0] MODE_X2PAIR = 2'b10;
  localparam logic [1:0] MODE_X8     = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_CSHOLD = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;
  // chip-select gap between a write and its read-back (verify builds only)
  localparam logic [2:0] ST_VGAP   = 3'd6;

  localparam logic [7:0] ERASED_BYTE = 8'hFF;

endpackage

// File: rtl/ospi_cmd_sequencer_if.sv
// Host-side request/response handshake bundle for the OSPI command sequencer.
interface ospi_cmd_sequencer_if #(parameter int ADDR_W = 24);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic [1:0]        req_mode;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ospi_cycle_timer.sv
// Loadable down-counter with freeze; done is high while the count is zero.
// Saturates at zero rather than wrapping.
module ospi_cycle_timer #(
  parameter int W = 1
)(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         freeze,
  output logic         done
);
  logic [W-1:0] cnt;

  // load wins over freeze; otherwise count down to zero and stop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   cnt <= '0;
    else if (load)                  cnt <= load_val;
    else if (!freeze && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/ospi_cmd_sequencer.sv
// OSPI command sequencer: turns host read/write/erase requests into timed
// flash accesses (CS setup, one-cycle strobe, read latency, CS hold) and
// returns a response. Optional OSPI_SEQ_VERIFY_EN adds a read-back compare
// after every write.
module ospi_cmd_sequencer
  import ospi_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1,
  parameter int RD_LAT   = 1
)(
  input  logic              clk,
  input  logic              reset_n,
  ospi_cmd_sequencer_if.slave host,
  input  logic              hold_req,
  output logic              busy,
  output logic              f_cs_n,
  output logic              f_write_enable,
  output logic              f_read_enable,
  output logic              f_erase_enable,
  output logic [ADDR_W-1:0] f_address,
  output logic [7:0]        f_data_in,
  output logic [1:0]        f_mode,
  output logic              f_hold_n,
  input  logic [7:0]        f_data_out
);
  localparam int MAX_SR  = (CS_SETUP > RD_LAT) ? CS_SETUP : RD_LAT;
  localparam int CNT_MAX = (MAX_SR > CS_HOLD) ? MAX_SR : CS_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       state, state_nxt;
  logic [1:0]       op_q;
  logic             hs;
  logic             rd_back;
  logic             rd_acc;
  logic             tmr_load, tmr_done, tmr_freeze;
  logic [CNT_W-1:0] tmr_val;

  assign hs = (state == ST_IDLE) && host.req_valid && host.req_ready;

`ifdef OSPI_SEQ_VERIFY_EN
  logic vfy_q;
  assign rd_back = vfy_q;
`else
  assign rd_back = 1'b0;
`endif

  // the access reads flash either for a host read or a write read-back
  assign rd_acc = (op_q == OP_READ) || rd_back;

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (hs) state_nxt = (host.req_op == OP_RSVD) ? ST_RESP : ST_SETUP;
      ST_SETUP:  if (!hold_req && tmr_done) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = rd_acc ? ST_WAIT : ST_CSHOLD;
      ST_WAIT:   if (tmr_done) state_nxt = ST_CSHOLD;
`ifdef OSPI_SEQ_VERIFY_EN
      ST_CSHOLD: if (tmr_done) state_nxt = (op_q == OP_WRITE && !vfy_q) ? ST_VGAP : ST_RESP;
      ST_VGAP:   state_nxt = ST_SETUP;
`else
      ST_CSHOLD: if (tmr_done) state_nxt = ST_RESP;
`endif
      ST_RESP:   if (host.rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // load the shared timer on entry to each timed state
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_nxt != state) begin
      case (state_nxt)
        ST_SETUP:  begin tmr_load = 1'b1; tmr_val = CNT_W'(CS_SETUP - 1); end
        ST_WAIT:   begin tmr_load = 1'b1; tmr_val = CNT_W'(RD_LAT - 1);   end
        ST_CSHOLD: begin tmr_load = 1'b1; tmr_val = CNT_W'(CS_HOLD - 1);  end
        default:   ;
      endcase
    end
  end

  assign tmr_freeze = (state == ST_SETUP) && hold_req;

  ospi_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .freeze   (tmr_freeze),
    .done     (tmr_done)
  );

  // state register and all outputs, registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      op_q           <= OP_READ;
      host.req_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= ERASED_BYTE;
      host.rsp_err   <= 1'b0;
      busy           <= 1'b0;
      f_cs_n         <= 1'b1;
      f_write_enable <= 1'b0;
      f_read_enable  <= 1'b0;
      f_erase_enable <= 1'b0;
      f_address      <= '0;
      f_data_in      <= 8'h00;
      f_mode         <= 2'b00;
      f_hold_n       <= 1'b1;
`ifdef OSPI_SEQ_VERIFY_EN
      vfy_q          <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      host.req_ready <= (state_nxt == ST_IDLE);
      host.rsp_valid <= (state_nxt == ST_RESP);
      busy           <= (state_nxt != ST_IDLE);
      f_cs_n         <= !(state_nxt inside {ST_SETUP, ST_EXEC, ST_WAIT, ST_CSHOLD});
      f_read_enable  <= (state_nxt == ST_EXEC) && rd_acc;
      f_write_enable <= (state_nxt == ST_EXEC) && (op_q == OP_WRITE) && !rd_back;
      f_erase_enable <= (state_nxt == ST_EXEC) && (op_q == OP_ERASE);
      f_hold_n       <= ~hold_req;
      if (hs) begin
        op_q           <= host.req_op;
        f_address      <= host.req_addr;
        f_data_in      <= host.req_wdata;
        f_mode         <= host.req_mode;
        host.rsp_rdata <= ERASED_BYTE;
        host.rsp_err   <= (host.req_op == OP_RSVD);
`ifdef OSPI_SEQ_VERIFY_EN
        vfy_q          <= 1'b0;
`endif
      end
      if (state == ST_WAIT && tmr_done) host.rsp_rdata <= f_data_out;
`ifdef OSPI_SEQ_VERIFY_EN
      if (state == ST_VGAP) vfy_q <= 1'b1;
      if (state == ST_CSHOLD && tmr_done && vfy_q) host.rsp_err <= (host.rsp_rdata != f_data_in);
`endif
    end
  end
endmodule

// File: tb/tb_ospi_cmd_sequencer.sv
// Directed bench for ospi_cmd_sequencer with a small behavioural flash model.
// Expected write results depend on OSPI_SEQ_VERIFY_EN.
module tb_ospi_cmd_sequencer;
  import ospi_pkg::*;

`ifdef OSPI_SEQ_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif
  localparam int WR_LAT = VFY ? 9 : 4;

  logic        clk, reset_n, hold_req, busy;
  logic        f_cs_n, f_write_enable, f_read_enable, f_erase_enable, f_hold_n;
  logic [23:0] f_address;
  logic [7:0]  f_data_in;
  logic [1:0]  f_mode;
  logic [7:0]  fdo = 8'h00;
  logic        force_en = 1'b0;
  logic [7:0]  force_val = 8'h00;

  ospi_cmd_sequencer_if #(.ADDR_W(24)) bus();

  ospi_cmd_sequencer #(.ADDR_W(24), .CS_SETUP(1), .CS_HOLD(1), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .host(bus), .hold_req(hold_req), .busy(busy),
    .f_cs_n(f_cs_n), .f_write_enable(f_write_enable), .f_read_enable(f_read_enable),
    .f_erase_enable(f_erase_enable), .f_address(f_address), .f_data_in(f_data_in),
    .f_mode(f_mode), .f_hold_n(f_hold_n), .f_data_out(fdo)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  // flash model: unwritten bytes read as erased, registered read data
  logic [7:0] mem [int];
  always @(posedge clk) begin
    if (!f_cs_n) begin
      if (f_write_enable) mem[int'(f_address)] = f_data_in;
      if (f_erase_enable) mem[int'(f_address)] = 8'hFF;
      if (f_read_enable)
        fdo <= force_en ? force_val : (mem.exists(int'(f_address)) ? mem[int'(f_address)] : 8'hFF);
    end
  end

  // activity monitor: strobe counts, CS-low cycles, responses, protocol violations
  int n_wr, n_rd, n_er, n_cslow, n_rsp, n_bad;
  initial begin n_wr = 0; n_rd = 0; n_er = 0; n_cslow = 0; n_rsp = 0; n_bad = 0; end
  always @(posedge clk) begin
    if (f_write_enable) n_wr++;
    if (f_read_enable)  n_rd++;
    if (f_erase_enable) n_er++;
    if (!f_cs_n) n_cslow++;
    if (bus.rsp_valid) n_rsp++;
    if (int'(f_write_enable) + int'(f_read_enable) + int'(f_erase_enable) > 1) n_bad++;
    if ((f_write_enable || f_read_enable || f_erase_enable) && f_cs_n) n_bad++;
  end

  int passed, total;
  int lat;
  logic [7:0] rd;
  logic er, cs_rsp;

  // issue one request and wait for its response; lat = cycles from handshake
  task automatic do_req(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd);
    int g;
    @(negedge clk);
    g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_mode = MODE_X8;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    rd = bus.rsp_rdata; er = bus.rsp_err; cs_rsp = f_cs_n;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hold_req = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0;
    bus.req_wdata = 8'h00; bus.req_mode = 2'b00; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, busy} !== 4'b0000)
      $display("FAIL reset_ctrl got=%b want=0000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, busy});
    else passed++;
    total++;
    if ({f_cs_n, f_write_enable, f_read_enable, f_erase_enable, f_hold_n} !== 5'b10001)
      $display("FAIL reset_flash got=%b want=10001", {f_cs_n, f_write_enable, f_read_enable, f_erase_enable, f_hold_n});
    else passed++;
    total++;
    if ({bus.rsp_rdata, f_address, f_data_in, f_mode} !== {8'hFF, 24'h0, 8'h00, 2'b00})
      $display("FAIL reset_data got=%h/%h/%h/%b want=ff/000000/00/00", bus.rsp_rdata, f_address, f_data_in, f_mode);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.req_ready); else passed++;
  endtask

  task automatic test_write_read();
    int w0, r0, b0;
    w0 = n_wr; r0 = n_rd; b0 = n_bad;
    do_req(OP_WRITE, 24'h000010, 8'h5A);
    total++;
    if (lat != WR_LAT || er !== 1'b0 || rd !== (VFY ? 8'h5A : 8'hFF))
      $display("FAIL write_rsp got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=%h", lat, er, rd, WR_LAT, VFY ? 8'h5A : 8'hFF);
    else passed++;
    total++;
    if (n_wr - w0 != 1) $display("FAIL write_pulses got=%0d want=1", n_wr - w0); else passed++;
    total++;
    if (f_mode !== MODE_X8) $display("FAIL write_mode got=%b want=11", f_mode); else passed++;
    do_req(OP_READ, 24'h000010, 8'h00);
    total++;
    if (lat != 5 || er !== 1'b0 || rd !== 8'h5A)
      $display("FAIL read_rsp got lat=%0d err=%b rd=%h want lat=5 err=0 rd=5a", lat, er, rd);
    else passed++;
    total++;
    if (n_rd - r0 != 1 + VFY) $display("FAIL read_pulses got=%0d want=%0d", n_rd - r0, 1 + VFY); else passed++;
    total++;
    if (n_bad != b0) $display("FAIL strobe_rules got=%0d want=0", n_bad - b0); else passed++;
  endtask

  task automatic test_erase();
    int e0;
    e0 = n_er;
    do_req(OP_ERASE, 24'h000010, 8'h00);
    total++;
    if (lat != 4 || er !== 1'b0 || rd !== 8'hFF || n_er - e0 != 1)
      $display("FAIL erase_rsp got lat=%0d err=%b rd=%h pulses=%0d want 4/0/ff/1", lat, er, rd, n_er - e0);
    else passed++;
    do_req(OP_READ, 24'h000010, 8'h00);
    total++;
    if (er !== 1'b0 || rd !== 8'hFF) $display("FAIL erase_read got err=%b rd=%h want 0/ff", er, rd); else passed++;
  endtask

  task automatic test_rsvd();
    int c0;
    c0 = n_cslow;
    do_req(OP_RSVD, 24'h000044, 8'h12);
    total++;
    if (lat != 1 || er !== 1'b1 || rd !== 8'hFF)
      $display("FAIL rsvd_rsp got lat=%0d err=%b rd=%h want 1/1/ff", lat, er, rd);
    else passed++;
    @(negedge clk);
    total++;
    if (n_cslow != c0) $display("FAIL rsvd_cs got=%0d want=0", n_cslow - c0); else passed++;
  endtask

  task automatic test_hold();
    int r0;
    do_req(OP_WRITE, 24'h000020, 8'hC3);
    r0 = n_rd;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_READ; bus.req_addr = 24'h000020; hold_req = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if (f_hold_n !== 1'b0) $display("FAIL hold_n_delay got=%b want=0", f_hold_n); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (n_rd != r0 || f_cs_n !== 1'b0 || busy !== 1'b1)
      $display("FAIL hold_setup got strobes=%0d cs_n=%b busy=%b want 0/0/1", n_rd - r0, f_cs_n, busy);
    else passed++;
    hold_req = 1'b0;
    lat = 4;
    while (!bus.rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    total++;
    if (lat != 8 || bus.rsp_rdata !== 8'hC3 || n_rd - r0 != 1 || f_hold_n !== 1'b1)
      $display("FAIL hold_done got lat=%0d rd=%h strobes=%0d hold_n=%b want 8/c3/1/1", lat, bus.rsp_rdata, n_rd - r0, f_hold_n);
    else passed++;
  endtask

  task automatic test_stall();
    bus.rsp_ready = 1'b0;
    do_req(OP_READ, 24'h000020, 8'h00);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hC3 || bus.req_ready !== 1'b0)
        $display("FAIL stall_hold%0d got v=%b rd=%h rdy=%b want 1/c3/0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      else passed++;
      if (i == 3) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL stall_release got v=%b rdy=%b want 0/1", bus.rsp_valid, bus.req_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_req(OP_READ, 24'h000020, 8'h00);
    total++;
    if (cs_rsp !== 1'b1 || rd !== 8'hC3) $display("FAIL b2b_first got cs_n=%b rd=%h want 1/c3", cs_rsp, rd); else passed++;
    do_req(OP_READ, 24'h000010, 8'h00);
    total++;
    if (cs_rsp !== 1'b1 || rd !== 8'hFF || lat != 5)
      $display("FAIL b2b_second got cs_n=%b rd=%h lat=%0d want 1/ff/5", cs_rsp, rd, lat);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int g, p0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_WRITE; bus.req_addr = 24'h000030; bus.req_wdata = 8'h77;
    @(negedge clk);
    bus.req_valid = 1'b0;
    g = 0;
    while (!f_write_enable && g < 20) begin @(negedge clk); g++; end
    total++;
    if (g >= 20) $display("FAIL mid_exec_reach got timeout want write strobe"); else passed++;
    p0 = n_rsp;
    reset_n = 1'b0;
    #1;
    total++;
    if ({f_cs_n, f_write_enable, f_read_enable, f_erase_enable, busy} !== 5'b10000)
      $display("FAIL mid_reset got=%b want=10000", {f_cs_n, f_write_enable, f_read_enable, f_erase_enable, busy});
    else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (n_rsp != p0 || bus.req_ready !== 1'b1)
      $display("FAIL mid_norsp got rsps=%0d rdy=%b want 0/1", n_rsp - p0, bus.req_ready);
    else passed++;
  endtask

`ifdef OSPI_SEQ_VERIFY_EN
  task automatic test_verify();
    force_en = 1'b1; force_val = 8'h00;
    do_req(OP_WRITE, 24'h000040, 8'h5A);
    force_en = 1'b0;
    total++;
    if (lat != 9 || er !== 1'b1 || rd !== 8'h00)
      $display("FAIL verify_mismatch got lat=%0d err=%b rd=%h want 9/1/00", lat, er, rd);
    else passed++;
  endtask
`endif

  initial begin
    passed = 0; total = 0;
    test_reset();
    test_write_read();
    test_erase();
    test_rsvd();
    test_hold();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef OSPI_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
